// File: rtl/mips_rf_pkg.sv
// Shared register-file types and widths for the 32x32 bank and its write-side sequencer.
package mips_rf_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int NUM_REGS = 32;
  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/regbank_wb_fifo.sv
// Dual-push / single-pop write queue, entries exposed oldest-first with a valid mask.
// Pushes into an empty queue flow straight to the pop port; WB_BYPASS_EN adds the data view.
module regbank_wb_fifo
  import mips_rf_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push0,
  input  wb_entry_t         push0_entry,
  input  logic              push1,
  input  wb_entry_t         push1_entry,
  output logic              pop,
  output wb_entry_t         pop_entry,
  output logic [ADDR_W-1:0] ent_dest [DEPTH],
`ifdef WB_BYPASS_EN
  output logic [DATA_W-1:0] ent_data [DEPTH],
`endif
  output logic [DEPTH-1:0]  ent_vld,
  output logic [CW-1:0]     count
);

  wb_entry_t       mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   wr_ptr_nxt1;
  logic [1:0]      n_push;
  logic [CW:0]     count_nxt;

  assign n_push      = {1'b0, push0} + {1'b0, push1};
  assign wr_ptr_nxt1 = wr_ptr + PW'(1);

  // Drain whenever anything is available, including this cycle's pushes.
  assign pop       = (count != '0) || push0 || push1;
  assign pop_entry = (count != '0) ? mem[rd_ptr] : (push0 ? push0_entry : push1_entry);
  assign count_nxt = {1'b0, count} + (CW + 1)'(n_push) - (CW + 1)'(pop);

  always_ff @(posedge clk) begin
    if (push0) mem[wr_ptr] <= push0_entry;
    if (push1) mem[push0 ? wr_ptr_nxt1 : wr_ptr] <= push1_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PW'(pop);
      wr_ptr <= wr_ptr + PW'(n_push);
      count  <= count_nxt[CW-1:0];
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_view
    logic [PW-1:0] idx;
    assign idx         = rd_ptr + PW'(k);
    assign ent_dest[k] = mem[idx].dest;
`ifdef WB_BYPASS_EN
    assign ent_data[k] = mem[idx].data;
`endif
    assign ent_vld[k]  = CW'(k) < count;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    count_nxt <= (CW + 1)'(DEPTH));

endmodule

// File: rtl/regbank_wb_ctrl.sv
// Write-side sequencer for the register bank: queues ALU/load results, one bank write per cycle.
// Empty-queue latency 1 cycle; alu_ready needs two free slots, loads never stall; WB_BYPASS_EN adds fwd_a/fwd_b.
module regbank_wb_ctrl
  import mips_rf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_dest,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_dest,
  input  logic [DATA_W-1:0] ld_data,
  output logic              W,
  output logic [ADDR_W-1:0] AdrC,
  output logic [DATA_W-1:0] C,
  input  logic [ADDR_W-1:0] qa_adr,
  input  logic [ADDR_W-1:0] qb_adr,
  output logic              busy_a,
  output logic              busy_b,
`ifdef WB_BYPASS_EN
  output logic [DATA_W-1:0] fwd_a,
  output logic [DATA_W-1:0] fwd_b,
`endif
  output logic              empty
);

  localparam int CW = $clog2(DEPTH) + 1;

  wb_entry_t         ld_entry;
  wb_entry_t         alu_entry;
  wb_entry_t         pop_entry;
  logic              ld_push;
  logic              alu_push;
  logic              pop;
  logic              run;
  logic [CW-1:0]     count;
  logic [CW-1:0]     free;
  logic [ADDR_W-1:0] ent_dest [DEPTH];
  logic [DEPTH-1:0]  ent_vld;
  logic [DEPTH-1:0]  hit_a;
  logic [DEPTH-1:0]  hit_b;
  logic              w_hit_a;
  logic              w_hit_b;

  assign ld_entry  = '{dest: ld_dest, data: ld_data};
  assign alu_entry = '{dest: alu_dest, data: alu_data};

  // Writes to r0 are discarded here; the ALU handshake still completes.
  assign ld_push  = ld_valid && (ld_dest != REG_ZERO);
  assign alu_push = alu_valid && alu_ready && (alu_dest != REG_ZERO);

  // Two free slots keep room for a load arriving alongside the ALU result.
  assign free      = CW'(DEPTH) - count;
  assign alu_ready = run && (free >= CW'(2));

`ifdef WB_BYPASS_EN
  logic [DATA_W-1:0] ent_data [DEPTH];
`endif

  regbank_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push0       (ld_push),
    .push0_entry (ld_entry),
    .push1       (alu_push),
    .push1_entry (alu_entry),
    .pop         (pop),
    .pop_entry   (pop_entry),
    .ent_dest    (ent_dest),
`ifdef WB_BYPASS_EN
    .ent_data    (ent_data),
`endif
    .ent_vld     (ent_vld),
    .count       (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run  <= 1'b0;
      W    <= 1'b0;
      AdrC <= '0;
      C    <= '0;
    end else begin
      run <= 1'b1;
      W   <= pop;
      if (pop) begin
        AdrC <= pop_entry.dest;
        C    <= pop_entry.data;
      end
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_hit
    assign hit_a[k] = ent_vld[k] && (ent_dest[k] == qa_adr);
    assign hit_b[k] = ent_vld[k] && (ent_dest[k] == qb_adr);
  end

  assign w_hit_a = W && (AdrC == qa_adr);
  assign w_hit_b = W && (AdrC == qb_adr);
  assign busy_a  = (qa_adr != REG_ZERO) && ((|hit_a) || w_hit_a);
  assign busy_b  = (qb_adr != REG_ZERO) && ((|hit_b) || w_hit_b);
  assign empty   = (count == '0) && !W;

`ifdef WB_BYPASS_EN
  // Entries are scanned oldest-first so the youngest match overrides; W is older than any entry.
  always_comb begin
    fwd_a = '0;
    fwd_b = '0;
    if (busy_a) begin
      if (w_hit_a) fwd_a = C;
      for (int k = 0; k < DEPTH; k++) begin
        if (hit_a[k]) fwd_a = ent_data[k];
      end
    end
    if (busy_b) begin
      if (w_hit_b) fwd_b = C;
      for (int k = 0; k < DEPTH; k++) begin
        if (hit_b[k]) fwd_b = ent_data[k];
      end
    end
  end
`endif

endmodule

// File: tb/tb_regbank_wb_ctrl.sv
// Scoreboard bench for regbank_wb_ctrl: random and directed ALU/load traffic against a queue model.
module tb_regbank_wb_ctrl;
  import mips_rf_pkg::*;

  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              alu_valid = 1'b0;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_dest = '0;
  logic [DATA_W-1:0] alu_data = '0;
  logic              ld_valid = 1'b0;
  logic [ADDR_W-1:0] ld_dest = '0;
  logic [DATA_W-1:0] ld_data = '0;
  logic              W;
  logic [ADDR_W-1:0] AdrC;
  logic [DATA_W-1:0] C;
  logic [ADDR_W-1:0] qa_adr = '0;
  logic [ADDR_W-1:0] qb_adr = '0;
  logic              busy_a;
  logic              busy_b;
  logic              empty;
`ifdef WB_BYPASS_EN
  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;
`endif

  always #5 clk = ~clk;

  regbank_wb_ctrl #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_dest  (alu_dest),
    .alu_data  (alu_data),
    .ld_valid  (ld_valid),
    .ld_dest   (ld_dest),
    .ld_data   (ld_data),
    .W         (W),
    .AdrC      (AdrC),
    .C         (C),
    .qa_adr    (qa_adr),
    .qb_adr    (qb_adr),
    .busy_a    (busy_a),
    .busy_b    (busy_b),
`ifdef WB_BYPASS_EN
    .fwd_a     (fwd_a),
    .fwd_b     (fwd_b),
`endif
    .empty     (empty)
  );

  // Pending bank write: destination, value, and first cycle it may appear on W.
  typedef struct {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
    int                avail;
  } wr_t;

  wr_t sb[$];
  int  tests = 0;
  int  fails = 0;
  int  cyc = 0;
  int  bank [NUM_REGS];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, want);
    end
  endtask

  // Youngest pending write to q, counting the write currently on the bank port.
  function automatic void model_hazard(input logic [ADDR_W-1:0] q, input bit wr, input wr_t cur,
                                       output bit b, output logic [DATA_W-1:0] f);
    b = 1'b0;
    f = '0;
    if (q != REG_ZERO) begin
      if (wr && cur.dest == q) begin
        b = 1'b1;
        f = cur.data;
      end
      foreach (sb[i]) begin
        if (sb[i].dest == q) begin
          b = 1'b1;
          f = sb[i].data;
        end
      end
    end
  endfunction

  bit                wr_now;
  wr_t               cur;
  bit                exp_ba;
  bit                exp_bb;
  logic [DATA_W-1:0] exp_fa;
  logic [DATA_W-1:0] exp_fb;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        check("rst_W", W, 0);
        check("rst_AdrC", AdrC, 0);
        check("rst_C", C, 0);
        check("rst_empty", empty, 1);
        check("rst_alu_ready", alu_ready, 0);
        check("rst_busy", {busy_a, busy_b}, 0);
      end else begin
        wr_now = (sb.size() > 0) && (sb[0].avail <= cyc);
        check("W", W, wr_now);
        if (wr_now) begin
          cur = sb.pop_front();
          check("AdrC", AdrC, cur.dest);
          check("C", C, cur.data);
          bank[cur.dest] = cur.data;
        end
        model_hazard(qa_adr, wr_now, cur, exp_ba, exp_fa);
        model_hazard(qb_adr, wr_now, cur, exp_bb, exp_fb);
        check("busy_a", busy_a, exp_ba);
        check("busy_b", busy_b, exp_bb);
`ifdef WB_BYPASS_EN
        check("fwd_a", fwd_a, exp_fa);
        check("fwd_b", fwd_b, exp_fb);
`endif
        check("empty", empty, (sb.size() == 0) && !wr_now);
        check("alu_ready", alu_ready, (DEPTH - sb.size()) >= 2);
        check("occupancy", sb.size() <= DEPTH, 1);
      end
    end
  end

  task automatic drive(input bit lv, input logic [ADDR_W-1:0] ld_d, input logic [DATA_W-1:0] ld_x,
                       input bit av, input logic [ADDR_W-1:0] al_d, input logic [DATA_W-1:0] al_x,
                       input logic [ADDR_W-1:0] qa, input logic [ADDR_W-1:0] qb);
    @(negedge clk);
    #1;
    ld_valid  = lv;
    ld_dest   = ld_d;
    ld_data   = ld_x;
    alu_valid = av;
    alu_dest  = al_d;
    alu_data  = al_x;
    qa_adr    = qa;
    qb_adr    = qb;
    if (lv && ld_d != REG_ZERO) sb.push_back('{dest: ld_d, data: ld_x, avail: cyc + 1});
    if (av && alu_ready && al_d != REG_ZERO) sb.push_back('{dest: al_d, data: al_x, avail: cyc + 1});
  endtask

  task automatic idle(input int n, input logic [ADDR_W-1:0] qa, input logic [ADDR_W-1:0] qb);
    for (int i = 0; i < n; i++) drive(0, '0, '0, 0, '0, '0, qa, qb);
  endtask

  task automatic rand_dest(output logic [ADDR_W-1:0] d);
    d = ADDR_W'($urandom_range(1, 9));
  endtask

  logic [ADDR_W-1:0] d0;
  logic [ADDR_W-1:0] d1;

  initial begin
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    drive(0, '0, '0, 1, 5'd5, 32'h1234, 5'd5, 5'd0);
    idle(3, 5'd5, 5'd0);

    drive(1, 5'd3, 32'hAAAA, 1, 5'd4, 32'hBBBB, 5'd3, 5'd4);
    idle(3, 5'd3, 5'd4);

    for (int i = 0; i < 8; i++) begin
      rand_dest(d0);
      rand_dest(d1);
      drive(1, d0, $urandom, 1, d1, $urandom, d0, d1);
    end
    idle(6, 5'd2, 5'd6);

    drive(0, '0, '0, 1, 5'd0, 32'hFFFF, 5'd0, 5'd0);
    idle(2, 5'd0, 5'd0);

    drive(0, '0, '0, 1, 5'd7, 32'd1, 5'd7, 5'd0);
    drive(0, '0, '0, 1, 5'd7, 32'd2, 5'd7, 5'd0);
    idle(4, 5'd7, 5'd0);
    check("r7_final", bank[7], 2);

    for (int i = 0; i < 3; i++) drive(1, 5'd10 + 5'(i), 32'h100 + i, 1, 5'd20 + 5'(i), 32'h200 + i, 5'd11, 5'd21);
    @(posedge clk);
    #2;
    rst_n     = 1'b0;
    ld_valid  = 1'b0;
    alu_valid = 1'b0;
    sb.delete();
    #1;
    check("async_rst_W", W, 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    idle(3, 5'd11, 5'd21);

    for (int i = 0; i < 400; i++) begin
      d0 = ADDR_W'($urandom_range(0, 7));
      d1 = ADDR_W'($urandom_range(0, 7));
      drive($urandom_range(0, 99) < 35, d0, $urandom, $urandom_range(0, 99) < 65, d1, $urandom,
            ADDR_W'($urandom_range(0, 7)), ADDR_W'($urandom_range(0, 7)));
    end

    for (int i = 0; i < 50 && sb.size() != 0; i++) idle(1, 5'd1, 5'd2);
    check("drain", sb.size(), 0);
    idle(1, 5'd0, 5'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
